// File: rtl/float_pkg.sv
// float_pkg: shared constants for the single-precision float datapath.
// Holds the exponent bias, field widths/positions and the int_to_float
// FSM state encoding. Imported by int_to_float and float_round.
package float_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EM_W     = EXP_W + MAN_W;
  localparam int INT_W    = 32;

  localparam int SIGN_POS = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

  // Exponent of a value whose leading one sits in bit INT_W-1.
  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + INT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } i2f_state_e;

endpackage

// File: rtl/float_round.sv
// float_round: combinational round-to-nearest-even of a normalized
// magnitude into packed {exp, mant}.
// Ports:
//   mag_frac  - normalized magnitude with the hidden one (bit 31) removed
//   exp       - biased exponent matching mag_frac
//   exp_man   - rounded {exp[7:0], mant[22:0]}
//   inexact   - guard or sticky bit was nonzero
module float_round
  import float_pkg::*;
(
  input  logic [30:0]      mag_frac,
  input  logic [EXP_W-1:0] exp,
  output logic [EM_W-1:0]  exp_man,
  output logic             inexact
);

  logic lsb;
  logic guard;
  logic sticky;
  logic round_up;

  always_comb begin
    lsb      = mag_frac[8];
    guard    = mag_frac[7];
    sticky   = |mag_frac[6:0];
    round_up = guard & (sticky | lsb);
    inexact  = guard | sticky;
    // Adding across the packed field lets an all-ones mantissa carry
    // straight into the exponent, which is exactly the renormalization
    // needed (mantissa wraps to zero, exponent increments).
    exp_man  = {exp, mag_frac[30:8]} + EM_W'(round_up);
  end

endmodule

// File: rtl/int_to_float.sv
// int_to_float: multi-cycle 32-bit integer (signed or unsigned) to
// IEEE-754 single-precision converter with valid/ready on both sides.
// Ports:
//   clk, rst_n             - clock, async active-low reset
//   in_valid/in_ready      - operand handshake
//   in_data, in_signed     - integer operand and its signedness
//   out_valid/out_ready    - result handshake
//   out_data               - {sign, exp[7:0], mant[22:0]}
//   out_inexact            - result was rounded
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// NORM  | shift mag left one bit per cycle until bit 31 is set
// ROUND | round and pack the result
// DONE  | result held with out_valid high until out_ready
module int_to_float
  import float_pkg::*;
#(
  parameter int EXP_BIAS_P = EXP_BIAS,
  parameter int INT_W_P    = INT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  i2f_state_e       state_q, state_d;
  logic             sign_q, sign_d;
  logic [31:0]      mag_q, mag_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_inexact_q, out_inexact_d;

  logic             acc_sign;
  logic [31:0]      acc_mag;
  logic [EM_W-1:0]  rnd_exp_man;
  logic             rnd_inexact;

  assign acc_sign = in_signed & in_data[31];
  // Negating 0x80000000 yields 0x80000000, which is the correct magnitude.
  assign acc_mag  = acc_sign ? (~in_data + 32'd1) : in_data;

  float_round u_round (
    .mag_frac (mag_q[30:0]),
    .exp      (exp_q),
    .exp_man  (rnd_exp_man),
    .inexact  (rnd_inexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sign_q        <= 1'b0;
      mag_q         <= '0;
      exp_q         <= '0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      mag_q         <= mag_d;
      exp_q         <= exp_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = (acc_mag == '0) ? ST_DONE : ST_NORM;
      ST_NORM:  if (mag_q[31]) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sign_d        = sign_q;
    mag_d         = mag_q;
    exp_d         = exp_q;
    out_data_d    = out_data_q;
    out_inexact_d = out_inexact_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = acc_sign;
          mag_d  = acc_mag;
          exp_d  = EXP_TOP;
          if (acc_mag == '0) begin
            // Zero is always +0, even for signed input.
            out_data_d    = '0;
            out_inexact_d = 1'b0;
          end
        end
      end
      ST_NORM: begin
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 1'b1;
        end
      end
      ST_ROUND: begin
        out_data_d    = {sign_q, rnd_exp_man};
        out_inexact_d = rnd_inexact;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_float.sv
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  int_to_float dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one operand; returns number of rising edges after the accept
  // edge before out_valid is seen (latency T+L gives L-1).
  task automatic send(input logic [31:0] d, input logic s, output int k);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_signed = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic convert(input string tag, input logic [31:0] d, input logic s,
                         input logic [31:0] exp_data, input logic exp_inx, input int exp_lat);
    int k;
    send(d, s, k);
    check({tag, " latency"}, 32'(k), 32'(exp_lat - 1));
    check({tag, " data"}, out_data, exp_data);
    check({tag, " inexact"}, {31'b0, out_inexact}, {31'b0, exp_inx});
    handshake();
    check({tag, " in_ready after"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int k;
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b0;
    #12;
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset inexact", {31'b0, out_inexact}, 32'd0);
    rst_n = 1'b1;

    convert("u1",        32'd1,          1'b0, 32'h3F800000, 1'b0, 34);
    convert("s-1",       32'hFFFFFFFF,   1'b1, 32'hBF800000, 1'b0, 34);
    convert("s_min",     32'h80000000,   1'b1, 32'hCF000000, 1'b0, 3);
    convert("u_msb",     32'h80000000,   1'b0, 32'h4F000000, 1'b0, 3);
    convert("u0",        32'd0,          1'b0, 32'h00000000, 1'b0, 1);
    convert("s0",        32'd0,          1'b1, 32'h00000000, 1'b0, 1);
    convert("tie_even",  32'd16777217,   1'b0, 32'h4B800000, 1'b1, 10);
    convert("tie_up",    32'd16777219,   1'b0, 32'h4B800002, 1'b1, 10);
    convert("u_max",     32'hFFFFFFFF,   1'b0, 32'h4F800000, 1'b1, 3);
    convert("s-1000",    32'hFFFFFC18,   1'b1, 32'hC47A0000, 1'b0, 25);
    convert("u1000_s",   32'd1000,       1'b1, 32'h447A0000, 1'b0, 25);

    // Backpressure: hold result for 10 cycles, pulse an ignored operand.
    send(32'd3, 1'b0, k);
    check("bp latency", 32'(k), 32'd32);
    held = out_data;
    check("bp data", held, 32'h40400000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = (i == 4);
      in_data  = 32'd7;
      @(posedge clk);
      #1;
      check("bp stable", out_data, 32'h40400000);
      check("bp in_ready", {31'b0, in_ready}, 32'd0);
      check("bp out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    handshake();
    check("bp in_ready after", {31'b0, in_ready}, 32'd1);
    convert("b2b", 32'd16777219, 1'b0, 32'h4B800002, 1'b1, 10);

    // Reset during NORM aborts the conversion asynchronously.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'd1; in_signed = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre-rst in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst in_ready", {31'b0, in_ready}, 32'd1);
    check("rst out_valid", {31'b0, out_valid}, 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst inexact", {31'b0, out_inexact}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("rst no result", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    convert("post_rst", 32'd1000, 1'b0, 32'h447A0000, 1'b0, 25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_to_float.md
Name: int_to_float

Overview:
- Multi-cycle converter from a 32-bit integer, signed or unsigned, to an IEEE-754 single-precision float.
- It produces operands for the float adder datapath: the encode side paired with the adder's float-consuming side.
- Rounding is round-to-nearest-even.
- Valid/ready handshake on both input and output; one conversion in flight at a time.

Parameters:
- EXP_BIAS, 127, single-precision exponent bias.
- INT_W, 32, input integer width. Fixed at 32; other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  source presents an operand
- in_ready  output  1  block can accept an operand
- in_data  input  32  integer operand
- in_signed  input  1  1 = in_data is two's complement; 0 = unsigned
- out_valid  output  1  result available
- out_ready  input  1  sink accepts result
- out_data  output  32  IEEE-754 result: sign[31], exp[30:23], mant[22:0]
- out_inexact  output  1  result was rounded (nonzero guard or sticky bit)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, out_inexact = 0.
  - Internal magnitude and exponent registers cleared.
- rst_n low mid-conversion aborts it immediately; no result is emitted.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch sign = in_signed & in_data[31], and mag = sign ? -in_data : in_data as a 32-bit unsigned value.
  - Set exp = EXP_BIAS + 31 = 158.
  - If mag == 0, go to DONE with out_data = 0x00000000 (positive zero, also for signed input) and inexact = 0.
  - Otherwise go to NORM.
- NORM:
  - If mag[31] == 1, go to ROUND.
  - Else mag <= mag << 1 and exp <= exp - 1; stay in NORM.
  - Exactly one bit per cycle: NORM occupies lz+1 cycles, where lz is the leading-zero count of mag.
- ROUND:
  - mant = mag[30:8], lsb = mag[8], guard = mag[7], sticky = |mag[6:0].
  - round_up = guard & (sticky | lsb).
  - If mant is all ones and round_up, then mant = 0 and exp = exp + 1.
  - out_data <= {sign, exp[7:0], mant + round_up}; out_inexact <= guard | sticky.
  - Go to DONE.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - out_data and out_inexact stay stable until out_valid & out_ready; then go to IDLE and clear out_valid.
  - No same-cycle re-accept: in_ready rises the cycle after the output handshake.
- in_ready is 0 in NORM, ROUND and DONE; in_valid is ignored there.
- Latency, with the accept edge at cycle T:
  - Nonzero input: out_valid is high starting cycle T+lz+3.
  - Zero input: out_valid is high starting T+1.
  - Worst case is input 1: T+34.
- Range: the maximum exponent is 159 (unsigned 0xFFFFFFFF rounding up), so overflow or infinity is impossible.
- Signed 0x80000000 has magnitude 0x80000000 and needs no special case.
- out_data holds its last value in IDLE; consumers use out_valid only.

Decomposition:
- Shared package float_pkg holds:
  - EXP_BIAS, EXP_W = 8, MAN_W = 23.
  - Field-position constants.
  - The FSM state encoding.
- One sub-module, float_round: combinational; takes the normalized mag and exp; returns the packed {exp, mant} and inexact. It is reused later by the adder's normalizer.

Test Plan:
- Unsigned 1 -> out_data 0x3F800000, inexact 0; out_valid first high at T+34.
- Signed 0xFFFFFFFF (-1) -> 0xBF800000, inexact 0. Signed 0x80000000 -> 0xCF000000, inexact 0.
- Zero, signed and unsigned -> 0x00000000, inexact 0, out_valid at T+1.
- Rounding:
  - 16777217 -> 0x4B800000, inexact 1 (tie to even).
  - 16777219 -> 0x4B800002, inexact 1.
  - Unsigned 0xFFFFFFFF -> 0x4F800000, inexact 1, out_valid at T+3 (mantissa carry into exponent).
- Backpressure: hold out_ready = 0 for 10 cycles in DONE.
  - out_data stays stable, in_ready stays 0, and a pulsed in_valid is ignored.
  - After the handshake, in_ready = 1 on the next cycle and a back-to-back operand converts correctly.
- Reset: drop rst_n during NORM -> all outputs go to reset values asynchronously. After release, the next operand 1000 -> 0x447A0000.
